// File: rtl/irq_conditioner.sv
// Purpose: per-source synchronise, glitch-filter and level/edge-condition 32 interrupt lines.
// Latency: raw edge sampled at E0 reaches irq after edge E0+SYNC_STAGES+FILTER_CYCLES; clear takes effect at the sampling edge.
// Backpressure: none; clr_valid is accepted every cycle and affects exactly one source.
// Optional: define IRQ_LOST_STATUS_EN to add sticky lost-edge status (lost / lost_clr ports).
module irq_conditioner #(
  parameter int SYNC_STAGES   = 2,  // legal 2..4
  parameter int FILTER_CYCLES = 3   // legal 0..15, 0 = no filter
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] raw_irq,
  input  logic [31:0] trig_mode,
  input  logic        clr_valid,
  input  logic [4:0]  clr_id,
`ifdef IRQ_LOST_STATUS_EN
  input  logic [31:0] lost_clr,
  output logic [31:0] lost,
`endif
  output logic [31:0] irq
);

  // Synchroniser chain: stage 0 samples the asynchronous lines, last stage is s.
  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0]                  s;

  // Filtered level per source and its one-cycle delayed copy for edge detection.
  logic [31:0] f;
  logic [31:0] f_d;
  logic [31:0] rise;

  // Latched edge state and its next value, shared by the output register.
  logic [31:0] pend;
  logic [31:0] pend_next;
  logic [31:0] clr_mask;

  // Shift raw lines through the synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_irq};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_no_filter
      // Filter bypassed: the synchronised level is used directly.
      assign f = s;
    end else begin : g_filter
      localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

      logic [31:0][3:0] cnt_q;
      logic [31:0]      f_q;

      // Accept a new level only after it has differed from f for FILTER_CYCLES edges in a row.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
          f_q   <= '0;
        end else begin
          for (int i = 0; i < 32; i++) begin
            if (s[i] == f_q[i]) begin
              cnt_q[i] <= 4'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
              f_q[i]   <= s[i];
              cnt_q[i] <= 4'd0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 4'd1;
            end
          end
        end
      end

      assign f = f_q;
    end
  endgenerate

  assign rise = f & ~f_d;

  // Decode the one-hot clear for the serviced source.
  always_comb begin
    clr_mask = '0;
    if (clr_valid) begin
      clr_mask[clr_id] = 1'b1;
    end
  end

  // Set beats clear; level-mode sources never hold a latched edge.
  assign pend_next = trig_mode & (rise | (pend & ~clr_mask));

  // Edge-detect delay, latched edges and the registered request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_d  <= '0;
      pend <= '0;
      irq  <= '0;
    end else begin
      f_d  <= f;
      pend <= pend_next;
      irq  <= (trig_mode & pend_next) | (~trig_mode & f);
    end
  end

`ifdef IRQ_LOST_STATUS_EN
  logic [31:0] lost_set;

  // An edge arriving on a source that is still pending and not being serviced is lost.
  assign lost_set = trig_mode & rise & pend & ~clr_mask;

  // Sticky lost status; a new loss beats a simultaneous software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost <= '0;
    end else begin
      lost <= lost_set | (lost & ~lost_clr);
    end
  end
`endif

endmodule

// File: doc/irq_conditioner.md
Name: irq_conditioner

Overview:
- Upstream front end of the 32-source fixed-priority interrupt controller; its irq output drives the controller's irq input directly.
- Per source: synchronises the asynchronous raw line, glitch-filters it, then presents it as level-sensitive or as a latched edge.
- Latched edges are held until the controller services that source, reported on a clear strobe with a 5-bit source ID.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per source; legal range 2..4.
- FILTER_CYCLES, 3, consecutive stable cycles needed to accept a change; 0 bypasses the filter; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- raw_irq  input  32  asynchronous interrupt lines; bit i is source i; bit 31 has highest downstream priority.
- trig_mode  input  32  per-source mode, synchronous: 1 = rising-edge latched, 0 = level.
- clr_valid  input  1  one-cycle strobe: the controller has serviced source clr_id.
- clr_id  input  5  index of the serviced source; qualified by clr_valid.
- irq  output  32  registered, conditioned requests to the controller.

Behaviour:
- Reset (async assert, sync release): sync chains, filtered state f, filter counters, pend and irq all 0.
- Synchroniser: raw_irq[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
- Filter, FILTER_CYCLES=F>0, per source, evaluated at each edge:
  - s==f: cnt<=0.
  - s!=f and cnt==F-1: f<=s, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - A pulse on s shorter than F cycles never changes f.
  - F=0: f=s combinationally; no counters are generated.
- Edge detect: f_d is f delayed one cycle; rise[i] = f[i] & ~f_d[i].
- Edge mode (trig_mode[i]=1):
  - rise[i] sets pend[i].
  - clr_valid with clr_id==i clears pend[i].
  - rise and clear in the same cycle: set wins.
  - A clear for a source that is not pending has no effect.
- Level mode (trig_mode[i]=0): pend[i] is forced to 0 and the clear strobe is ignored for that source.
- Output register: irq[i] <= trig_mode[i] ? (pend_next[i]) : f[i].
  - Latency: raw_irq rising is first sampled at edge E0; irq rises after edge E0+SYNC_STAGES+FILTER_CYCLES.
  - With defaults that is edge E0+5.
  - A falling raw line follows the same latency in level mode only.
- Clear latency: clr_valid sampled at edge C; irq[i] is low after edge C, unless a new edge is set at C.
- Mode change edge→level: pend[i] is cleared next edge and irq follows f. Level→edge: pend starts at 0, and a source that is already high is not latched until its next rising edge.
- Multiple sources are independent; the clear affects only one source per cycle.
- Reset mid-operation: all pending edges are discarded; no latched state survives reset.

Optional Feature:
- Macro: IRQ_LOST_STATUS_EN.
- When defined, adds ports lost (output, 32) and lost_clr (input, 32).
- lost[i] sets when rise[i] occurs in edge mode while pend[i] is already 1 and not being cleared that cycle.
- lost bits are sticky and cleared by lost_clr[i]=1 for one cycle. Set wins over lost_clr in the same cycle.
- Reset value of lost is 0.
- When undefined: no lost/lost_clr ports, no lost registers; all other behaviour is identical.

Test Plan:
- Reset, then hold raw_irq=32'h0000_0008 with trig_mode=0 (defaults) -> irq[3] rises after the 5th edge counting the first sampling edge; deassert raw -> irq[3] falls 5 edges later.
- Glitch rejection: 2-cycle pulse on raw_irq[7] -> irq stays 32'h0; 3-cycle pulse in edge mode -> irq[7] latches and stays high after raw returns low.
- Edge latch and clear: trig_mode=32'h8000_0000, pulse raw_irq[31] for 4 cycles -> irq[31]=1 held; clr_valid=1, clr_id=31 for one cycle -> irq[31]=0 the next edge; clr_id=14 -> no change.
- Simultaneous set/clear: new filtered rise on source 14 in the same cycle as clr_valid with clr_id=14 -> irq[14] stays 1.
- Mixed pattern 32'h8000_66CF: bits 31,14,13 in edge mode, rest level -> after latency irq=32'h8000_66CF; clear 31, then 14, then 13 while raw stays high -> irq steps to 32'h0000_66CF, 32'h0000_26CF, 32'h0000_06CF.
- Async reset mid-latch (pend[13]=1), reset pulsed between edges -> irq=0 immediately; IRQ_LOST_STATUS_EN: second edge on pending source 2 -> lost=32'h4, lost_clr=32'h4 -> lost=0.
